// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port memory arbiter (optional MEM_ARB_FIXED_PRIO_EN: requester 0 always wins contention)
module mem_arbiter #(
  parameter int LOCATIONS = 16,
  parameter int LOC_SIZE  = 8,
  localparam int AW       = $clog2(LOCATIONS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic                req0_op,
  input  logic [AW-1:0]       req0_addr,
  input  logic [LOC_SIZE-1:0] req0_wdata,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic                req1_op,
  input  logic [AW-1:0]       req1_addr,
  input  logic [LOC_SIZE-1:0] req1_wdata,
  output logic                req1_ready,
  output logic                rsp0_valid,
  output logic [LOC_SIZE-1:0] rsp0_rdata,
  output logic                rsp1_valid,
  output logic [LOC_SIZE-1:0] rsp1_rdata,
  output logic                mem_reset,
  output logic                mem_op,
  output logic [AW-1:0]       mem_addr,
  output logic [LOC_SIZE-1:0] mem_data_in,
  input  logic [LOC_SIZE-1:0] mem_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                op_q, op_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [LOC_SIZE-1:0] wdata_q, wdata_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [LOC_SIZE-1:0] rdata0_q, rdata0_d;
  logic [LOC_SIZE-1:0] rdata1_q, rdata1_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic                grant0, grant1;
  logic                in_access;

  // Pick the winner in IDLE; last_q == 1 means requester 0 is owed the next contended grant
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == S_IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        grant0 = 1'b1;
`else
        grant0 = last_q;
        grant1 = ~last_q;
`endif
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // Transaction sequencing: latch on grant, drive memory, capture read data, pulse response
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    last_d       = last_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          op_d    = grant1 ? req1_op    : req0_op;
          addr_d  = grant1 ? req1_addr  : req0_addr;
          wdata_d = grant1 ? req1_wdata : req0_wdata;
          owner_d = grant1;
          last_d  = grant1;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (!op_q) begin
          if (owner_q) rdata1_d = mem_data_out;
          else         rdata0_d = mem_data_out;
        end
        rsp0_valid_d = ~owner_q;
        rsp1_valid_d = owner_q;
        state_d      = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  // Memory port idles as a read of word 0 outside ACCESS and while reset is high
  always_comb begin
    in_access   = (state_q == S_ACCESS) && !reset;
    mem_reset   = reset;
    mem_op      = in_access & op_q;
    mem_addr    = in_access ? addr_q  : '0;
    mem_data_in = in_access ? wdata_q : '0;
    req0_ready  = grant0;
    req1_ready  = grant1;
    rsp0_valid  = rsp0_valid_q;
    rsp1_valid  = rsp1_valid_q;
    rsp0_rdata  = rdata0_q;
    rsp1_rdata  = rdata1_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int LOCATIONS = 16;
  localparam int LOC_SIZE  = 8;
  localparam int AW        = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                req0_valid, req0_op, req0_ready;
  logic [AW-1:0]       req0_addr;
  logic [LOC_SIZE-1:0] req0_wdata;
  logic                req1_valid, req1_op, req1_ready;
  logic [AW-1:0]       req1_addr;
  logic [LOC_SIZE-1:0] req1_wdata;
  logic                rsp0_valid, rsp1_valid;
  logic [LOC_SIZE-1:0] rsp0_rdata, rsp1_rdata;
  logic                mem_reset, mem_op;
  logic [AW-1:0]       mem_addr;
  logic [LOC_SIZE-1:0] mem_data_in, mem_data_out;

  logic                mem_clear;
  logic [LOC_SIZE-1:0] mem [LOCATIONS];
  logic [LOC_SIZE-1:0] sb [LOCATIONS];
  logic [LOC_SIZE-1:0] exp_rdata0, exp_rdata1;
  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.LOCATIONS(LOCATIONS), .LOC_SIZE(LOC_SIZE)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_reset(mem_reset), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: read data appears the cycle after the address
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < LOCATIONS; i++) mem[i] <= '0;
      mem_data_out <= '0;
    end else begin
      if (mem_op) mem[mem_addr] <= mem_data_in;
      mem_data_out <= mem[mem_addr];
    end
  end

  // One complete transaction from requester n, starting just after a negedge in IDLE
  task automatic drive_txn(input int n, input logic op, input logic [AW-1:0] addr,
                           input logic [LOC_SIZE-1:0] wdata, input string tag);
    logic rdy_n, rdy_o, rsp_n, rsp_o;
    if (n == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_addr = addr; req1_wdata = wdata;
    end
    #1;
    rdy_n = (n == 0) ? req0_ready : req1_ready;
    rdy_o = (n == 0) ? req1_ready : req0_ready;
    n_checks++;
    if (rdy_n !== 1'b1 || rdy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready: got own=%b other=%b exp own=1 other=0", tag, rdy_n, rdy_o);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    n_checks++;
    if (mem_op !== op || mem_addr !== addr || mem_data_in !== (op ? wdata : 8'h00)) begin
      n_fail++;
      $display("FAIL %s access: got op=%b addr=%0d din=%h exp op=%b addr=%0d din=%h",
               tag, mem_op, mem_addr, mem_data_in, op, addr, (op ? wdata : 8'h00));
    end
    if (op) sb[addr] = wdata;
    else if (n == 0) exp_rdata0 = sb[addr];
    else exp_rdata1 = sb[addr];
    @(negedge clk); #1;
    n_checks++;
    if (mem_op !== 1'b0 || mem_addr !== 4'd0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s capture: got op=%b addr=%0d rsp0=%b rsp1=%b exp all 0",
               tag, mem_op, mem_addr, rsp0_valid, rsp1_valid);
    end
    @(negedge clk); #1;
    rsp_n = (n == 0) ? rsp0_valid : rsp1_valid;
    rsp_o = (n == 0) ? rsp1_valid : rsp0_valid;
    n_checks++;
    if (rsp_n !== 1'b1 || rsp_o !== 1'b0 || rsp0_rdata !== exp_rdata0 || rsp1_rdata !== exp_rdata1) begin
      n_fail++;
      $display("FAIL %s resp: got own=%b other=%b rd0=%h rd1=%h exp own=1 other=0 rd0=%h rd1=%h",
               tag, rsp_n, rsp_o, rsp0_rdata, rsp1_rdata, exp_rdata0, exp_rdata1);
    end
    @(negedge clk); #1;
    n_checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_rdata !== exp_rdata0 ||
        rsp1_rdata !== exp_rdata1 || mem_addr !== 4'd0) begin
      n_fail++;
      $display("FAIL %s after: got rsp0=%b rsp1=%b rd0=%h rd1=%h addr=%0d exp 0 0 %h %h 0",
               tag, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, mem_addr, exp_rdata0, exp_rdata1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_clear = 1'b1;
    req0_valid = 1'b1; req0_op = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_op = 1'b0; req1_addr = '0; req1_wdata = '0;
    exp_rdata0 = '0; exp_rdata1 = '0;
    for (int i = 0; i < LOCATIONS; i++) sb[i] = '0;
    repeat (2) begin
      @(negedge clk); #1;
      n_checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || mem_op !== 1'b0 || mem_addr !== 4'd0 ||
          mem_data_in !== 8'h00 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
          rsp0_rdata !== 8'h00 || rsp1_rdata !== 8'h00 || mem_reset !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_state: got rdy=%b%b op=%b addr=%0d din=%h rsp=%b%b rd=%h/%h mrst=%b exp all 0, mrst=1",
                 req0_ready, req1_ready, mem_op, mem_addr, mem_data_in, rsp0_valid, rsp1_valid,
                 rsp0_rdata, rsp1_rdata, mem_reset);
      end
    end
    reset = 1'b0; mem_clear = 1'b0;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || mem_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL first_idle_ready: got rdy0=%b rdy1=%b mrst=%b exp 1 0 0", req0_ready, req1_ready, mem_reset);
    end
    // Valid dropped before the edge: no grant and nothing happens afterwards
    req0_valid = 1'b0;
    #1;
    n_checks++;
    if (req0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_valid_ready: got %b exp 0", req0_ready);
    end
    repeat (4) begin
      @(negedge clk); #1;
      n_checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || mem_op !== 1'b0 || mem_addr !== 4'd0) begin
        n_fail++;
        $display("FAIL drop_valid_quiet: got rsp=%b%b op=%b addr=%0d exp 0 0 0 0",
                 rsp0_valid, rsp1_valid, mem_op, mem_addr);
      end
    end
  endtask

  task automatic test_write_read();
    drive_txn(0, 1'b1, 4'd3, 8'hA5, "wr0_a3");
    drive_txn(0, 1'b0, 4'd3, 8'h00, "rd0_a3");
  endtask

  task automatic test_cross();
    drive_txn(1, 1'b1, 4'd15, 8'hFF, "wr1_a15");
    drive_txn(0, 1'b0, 4'd15, 8'h00, "rd0_a15");
  endtask

  task automatic test_round_robin();
    int owner;
    reset = 1'b1;
    req0_valid = 1'b1; req0_op = 1'b0; req0_addr = 4'd3;
    req1_valid = 1'b1; req1_op = 1'b0; req1_addr = 4'd15;
    exp_rdata0 = '0; exp_rdata1 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      owner = 0;
`else
      owner = (k / 4) % 2;
`endif
      #1;
      n_checks++;
      if ((k % 4) == 0) begin
        if (req0_ready !== (owner == 0) || req1_ready !== (owner == 1) ||
            rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_grant k=%0d: got rdy=%b%b rsp=%b%b exp owner=%0d no rsp",
                   k, req0_ready, req1_ready, rsp0_valid, rsp1_valid, owner);
        end
      end else if ((k % 4) == 3) begin
        if (owner == 0) exp_rdata0 = 8'hA5;
        else exp_rdata1 = 8'hFF;
        if (rsp0_valid !== (owner == 0) || rsp1_valid !== (owner == 1) ||
            rsp0_rdata !== exp_rdata0 || rsp1_rdata !== exp_rdata1 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_resp k=%0d: got rsp=%b%b rd=%h/%h rdy=%b%b exp owner=%0d rd=%h/%h",
                   k, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, req0_ready, req1_ready,
                   owner, exp_rdata0, exp_rdata1);
        end
      end else begin
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_busy k=%0d: got rdy=%b%b rsp=%b%b exp all 0",
                   k, req0_ready, req1_ready, rsp0_valid, rsp1_valid);
        end
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_op = 1'b0; req0_addr = 4'd3;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_grant: got rdy0=%b exp 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_op !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_in_reset: got op=%b rdy=%b%b exp 0 0 0", mem_op, req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1; req1_op = 1'b0; req1_addr = 4'd15;
    exp_rdata0 = '0; exp_rdata1 = '0;
    #1;
    n_checks++;
    if (rsp0_valid !== 1'b0 || rsp0_rdata !== 8'h00 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_abandon: got rsp0=%b rd0=%h rdy=%b%b exp 0 00 0 0",
               rsp0_valid, rsp0_rdata, req0_ready, req1_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_regrant: got rdy=%b%b rsp0=%b exp 1 0 0", req0_ready, req1_ready, rsp0_valid);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    exp_rdata0 = 8'hA5;
    n_checks++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_rdata !== exp_rdata0) begin
      n_fail++;
      $display("FAIL mid_resp: got rsp=%b%b rd0=%h exp 1 0 %h", rsp0_valid, rsp1_valid, rsp0_rdata, exp_rdata0);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_cross();
    test_round_robin();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
